// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file write-back slice: widths,
// register reset value and the debug write FSM encoding.
package regfile_writeback_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [DATA_W-1:0] REG_RESET_VAL = '0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK       = 2'd1,
    WAIT_DROP = 2'd2
  } dbg_state_t;

endpackage

// File: rtl/regfile_writeback_array.sv
// 32 x DATA_W register storage: one synchronous write port, two
// asynchronous read ports, asynchronous clear of every entry.
module regfile_writeback_array #(
  parameter int DATA_W = regfile_writeback_pkg::DATA_W,
  parameter int NREGS  = 32
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   we,
  input  logic [regfile_writeback_pkg::REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]                      wdata,
  input  logic [regfile_writeback_pkg::REG_ADDR_W-1:0] raddr1,
  input  logic [regfile_writeback_pkg::REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]                      rdata1,
  output logic [DATA_W-1:0]                      rdata2
);
  import regfile_writeback_pkg::*;

  logic [DATA_W-1:0] regs [NREGS];

  // Clear every entry on reset, otherwise perform the single write
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= DATA_W'(REG_RESET_VAL);
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/regfile_writeback.sv
// Write side of the MIPS register file: a one-entry write-back stage that
// commits to the array one edge after capture, forwarded read ports, a
// req/ack debug write port and a commit counter.
module regfile_writeback #(
  parameter int DATA_W         = regfile_writeback_pkg::DATA_W,
  parameter int NREGS          = 32,
  parameter int ZERO_HARDWIRED = 0
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   wb_valid,
  input  logic                                   RegWrite,
  input  logic                                   MemtoReg,
  input  logic [regfile_writeback_pkg::REG_ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0]                      ALUOut,
  input  logic [DATA_W-1:0]                      MemData,
  input  logic [regfile_writeback_pkg::REG_ADDR_W-1:0] ReadReg1,
  input  logic [regfile_writeback_pkg::REG_ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0]                      A,
  output logic [DATA_W-1:0]                      B,
  input  logic                                   dbg_req,
  input  logic [regfile_writeback_pkg::REG_ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0]                      dbg_data,
  output logic                                   dbg_ack,
  output logic [31:0]                            commit_count
);
  import regfile_writeback_pkg::*;

  dbg_state_t dbg_state, dbg_next;

  logic                  stage_valid;
  logic [REG_ADDR_W-1:0] stage_dest;
  logic [DATA_W-1:0]     stage_data;
  logic [31:0]           commit_cnt;

  logic                  zero_wb;
  logic                  zero_dbg;
  logic                  capture;
  logic                  dbg_write;
  logic                  arr_we;
  logic [REG_ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0]     arr_wdata;
  logic [DATA_W-1:0]     rd1;
  logic [DATA_W-1:0]     rd2;

  // With a hardwired zero register, writes aimed at reg 0 are dropped
  // before they reach the stage, so they never commit or count.
  assign zero_wb  = (ZERO_HARDWIRED != 0) && (WriteReg == '0);
  assign zero_dbg = (ZERO_HARDWIRED != 0) && (dbg_addr == '0);
  assign capture  = wb_valid && RegWrite && !zero_wb;

  // Write-back stage register; a reset discards any pending result
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stage_valid <= 1'b0;
      stage_dest  <= '0;
      stage_data  <= '0;
    end else begin
      stage_valid <= capture;
      if (capture) begin
        stage_dest <= WriteReg;
        stage_data <= MemtoReg ? MemData : ALUOut;
      end
    end
  end

  // Count every stage commit; wraps naturally at 2^32
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      commit_cnt <= '0;
    end else if (stage_valid) begin
      commit_cnt <= commit_cnt + 32'd1;
    end
  end

  assign commit_count = commit_cnt;

  // Debug FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dbg_state <= IDLE;
    end else begin
      dbg_state <= dbg_next;
    end
  end

  // Debug FSM: writes only while the stage is empty, so it never collides with a commit
  always_comb begin
    dbg_next  = dbg_state;
    dbg_write = 1'b0;
    dbg_ack   = 1'b0;
    case (dbg_state)
      IDLE: begin
        if (dbg_req && !stage_valid) begin
          dbg_write = 1'b1;
          dbg_next  = ACK;
        end
      end
      ACK: begin
        dbg_ack  = 1'b1;
        dbg_next = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!dbg_req) begin
          dbg_next = IDLE;
        end
      end
      default: dbg_next = IDLE;
    endcase
  end

  // Single array write port shared by stage commit and debug write
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = stage_dest;
    arr_wdata = stage_data;
    if (stage_valid) begin
      arr_we = 1'b1;
    end else if (dbg_write && !zero_dbg) begin
      arr_we    = 1'b1;
      arr_waddr = dbg_addr;
      arr_wdata = dbg_data;
    end
  end

  regfile_writeback_array #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_array (
    .CLK    (CLK),
    .RESET  (RESET),
    .we     (arr_we),
    .waddr  (arr_waddr),
    .wdata  (arr_wdata),
    .raddr1 (ReadReg1),
    .raddr2 (ReadReg2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // Read ports forward the pending stage result ahead of the array
  always_comb begin
    A = rd1;
    B = rd2;
    if (stage_valid && stage_dest == ReadReg1) A = stage_data;
    if (stage_valid && stage_dest == ReadReg2) B = stage_data;
    if ((ZERO_HARDWIRED != 0) && ReadReg1 == '0) A = '0;
    if ((ZERO_HARDWIRED != 0) && ReadReg2 == '0) B = '0;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: one instance with an ordinary
// reg 0 and one with a hardwired zero register, both driven from the same
// inputs and compared against an architectural register-file model.
module tb_regfile_writeback;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        wb_valid;
  logic        RegWrite;
  logic        MemtoReg;
  logic [4:0]  WriteReg;
  logic [31:0] ALUOut;
  logic [31:0] MemData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic [31:0] a_o [2];
  logic [31:0] b_o [2];
  logic        ack_o [2];
  logic [31:0] cnt_o [2];

  int total = 0;
  int bad   = 0;

  // Architectural model: results become visible on the edge they are captured
  logic [31:0] m_regs [2][32];
  logic [31:0] m_count [2];
  bit          m_pend [2];
  int          m_phase [2];

  regfile_writeback #(.DATA_W(32), .NREGS(32), .ZERO_HARDWIRED(0)) dut (
    .CLK(CLK), .RESET(RESET), .wb_valid(wb_valid), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .WriteReg(WriteReg), .ALUOut(ALUOut), .MemData(MemData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .A(a_o[0]), .B(b_o[0]),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_ack(ack_o[0]), .commit_count(cnt_o[0])
  );

  regfile_writeback #(.DATA_W(32), .NREGS(32), .ZERO_HARDWIRED(1)) dut_z (
    .CLK(CLK), .RESET(RESET), .wb_valid(wb_valid), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .WriteReg(WriteReg), .ALUOut(ALUOut), .MemData(MemData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .A(a_o[1]), .B(b_o[1]),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_ack(ack_o[1]), .commit_count(cnt_o[1])
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) m_regs[k][r] = '0;
      m_count[k] = '0;
      m_pend[k]  = 1'b0;
      m_phase[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs held across it
  task automatic model_edge();
    bit zh;
    bit cap;
    for (int k = 0; k < 2; k++) begin
      zh = (k == 1);
      if (m_pend[k]) m_count[k] = m_count[k] + 32'd1;
      case (m_phase[k])
        0: if (dbg_req && !m_pend[k]) begin
             if (!(zh && dbg_addr == 5'd0)) m_regs[k][dbg_addr] = dbg_data;
             m_phase[k] = 1;
           end
        1: m_phase[k] = 2;
        default: if (!dbg_req) m_phase[k] = 0;
      endcase
      cap = wb_valid && RegWrite && !(zh && WriteReg == 5'd0);
      if (cap) m_regs[k][WriteReg] = MemtoReg ? MemData : ALUOut;
      m_pend[k] = cap;
    end
  endtask

  function automatic logic [31:0] exp_read(int k, logic [4:0] addr);
    if (k == 1 && addr == 5'd0) return 32'h0;
    return m_regs[k][addr];
  endfunction

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    wb_valid = 0; RegWrite = 0; MemtoReg = 0; WriteReg = 0;
    ALUOut = 0; MemData = 0; ReadReg1 = 0; ReadReg2 = 0;
    dbg_req = 0; dbg_addr = 0; dbg_data = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    ReadReg1 = 5'd3;
    ReadReg2 = 5'd4;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (a_o[k] !== 32'h0) begin bad++; $display("[TB] FAIL reset_A[%0d]: got %h want 0", k, a_o[k]); end
      total++;
      if (b_o[k] !== 32'h0) begin bad++; $display("[TB] FAIL reset_B[%0d]: got %h want 0", k, b_o[k]); end
      total++;
      if (cnt_o[k] !== 32'h0) begin bad++; $display("[TB] FAIL reset_count[%0d]: got %0d want 0", k, cnt_o[k]); end
      total++;
      if (ack_o[k] !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack[%0d]: got %b want 0", k, ack_o[k]); end
    end
  endtask

  task automatic test_debug_write();
    int  acks [2];
    bit  seen;
    acks[0] = 0; acks[1] = 0;
    dbg_req = 1; dbg_addr = 5'd1; dbg_data = 32'h4; ReadReg1 = 5'd1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (ack_o[k] !== (m_phase[k] == 1)) begin
          bad++; $display("[TB] FAIL dbg_ack_timing[%0d] cyc %0d: got %b want %b", k, i, ack_o[k], m_phase[k] == 1);
        end
        if (ack_o[k] === 1'b1) acks[k]++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (acks[k] != 1) begin bad++; $display("[TB] FAIL dbg_ack_pulses[%0d]: got %0d want 1", k, acks[k]); end
      total++;
      if (a_o[k] !== 32'h4) begin bad++; $display("[TB] FAIL dbg_read_r1[%0d]: got %h want 4", k, a_o[k]); end
    end
    // Dropping the request must bring the FSM back so a new request is taken
    dbg_req = 0;
    cycle();
    dbg_req = 1; dbg_addr = 5'd3; dbg_data = 32'h33;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      cycle();
      if (ack_o[0] === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL dbg_return_idle: got no ack want ack within 5 cycles"); end
    dbg_req = 0;
    cycle();
    cycle();
    ReadReg2 = 5'd3;
    #1;
    total++;
    if (b_o[0] !== 32'h33) begin bad++; $display("[TB] FAIL dbg_read_r3: got %h want 33", b_o[0]); end
  endtask

  task automatic test_capture();
    wb_valid = 1; RegWrite = 1; MemtoReg = 0; WriteReg = 5'd2; ALUOut = 32'h7;
    ReadReg2 = 5'd2;
    cycle();
    wb_valid = 0; RegWrite = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (b_o[k] !== 32'h7) begin bad++; $display("[TB] FAIL capture_forward[%0d]: got %h want 7", k, b_o[k]); end
      total++;
      if (cnt_o[k] !== 32'd0) begin bad++; $display("[TB] FAIL capture_count0[%0d]: got %0d want 0", k, cnt_o[k]); end
    end
    cycle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (b_o[k] !== 32'h7) begin bad++; $display("[TB] FAIL capture_array[%0d]: got %h want 7", k, b_o[k]); end
      total++;
      if (cnt_o[k] !== 32'd1) begin bad++; $display("[TB] FAIL capture_count1[%0d]: got %0d want 1", k, cnt_o[k]); end
    end
  endtask

  task automatic test_memtoreg();
    wb_valid = 1; RegWrite = 1; MemtoReg = 1; WriteReg = 5'd5;
    MemData = 32'hDEADBEEF; ALUOut = 32'h1;
    cycle();
    RegWrite = 0; MemtoReg = 0; ALUOut = 32'h99; ReadReg1 = 5'd5;
    #1;
    total++;
    if (a_o[0] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL memtoreg_forward: got %h want deadbeef", a_o[0]); end
    cycle();
    wb_valid = 0;
    cycle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (a_o[k] !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL memtoreg_array[%0d]: got %h want deadbeef", k, a_o[k]); end
      total++;
      if (cnt_o[k] !== 32'd2) begin bad++; $display("[TB] FAIL regwrite0_count[%0d]: got %0d want 2", k, cnt_o[k]); end
    end
  endtask

  task automatic test_back_to_back();
    ReadReg1 = 5'd9;
    wb_valid = 1; RegWrite = 1; MemtoReg = 0; WriteReg = 5'd9; ALUOut = 32'hA;
    cycle();
    total++;
    if (a_o[0] !== 32'hA) begin bad++; $display("[TB] FAIL b2b_first: got %h want a", a_o[0]); end
    ALUOut = 32'hB;
    dbg_req = 1; dbg_addr = 5'd12; dbg_data = 32'h77;
    cycle();
    wb_valid = 0; RegWrite = 0;
    #1;
    total++;
    if (a_o[0] !== 32'hB) begin bad++; $display("[TB] FAIL b2b_second: got %h want b", a_o[0]); end
    total++;
    if (ack_o[0] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_ack_deferred1: got %b want 0", ack_o[0]); end
    cycle();
    total++;
    if (ack_o[0] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_ack_deferred2: got %b want 0", ack_o[0]); end
    cycle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (ack_o[k] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ack_after_drain[%0d]: got %b want 1", k, ack_o[k]); end
    end
    dbg_req = 0; ReadReg2 = 5'd12;
    cycle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (a_o[k] !== 32'hB) begin bad++; $display("[TB] FAIL b2b_final_r9[%0d]: got %h want b", k, a_o[k]); end
      total++;
      if (b_o[k] !== 32'h77) begin bad++; $display("[TB] FAIL b2b_dbg_r12[%0d]: got %h want 77", k, b_o[k]); end
      total++;
      if (cnt_o[k] !== 32'd4) begin bad++; $display("[TB] FAIL b2b_count[%0d]: got %0d want 4", k, cnt_o[k]); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    ReadReg1 = 5'd6;
    wb_valid = 1; RegWrite = 1; MemtoReg = 0; WriteReg = 5'd6; ALUOut = 32'h55;
    cycle();
    wb_valid = 0; RegWrite = 0;
    dbg_req = 1; dbg_addr = 5'd13; dbg_data = 32'h31;
    #1;
    total++;
    if (a_o[0] !== 32'h55) begin bad++; $display("[TB] FAIL midreset_pending: got %h want 55", a_o[0]); end
    RESET = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (a_o[k] !== 32'h0) begin bad++; $display("[TB] FAIL midreset_A[%0d]: got %h want 0", k, a_o[k]); end
      total++;
      if (cnt_o[k] !== 32'h0) begin bad++; $display("[TB] FAIL midreset_count[%0d]: got %0d want 0", k, cnt_o[k]); end
    end
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      cycle();
      if (ack_o[0] === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("[TB] FAIL midreset_dbg_reserviced: got no ack want ack within 5 cycles"); end
    dbg_req = 0; ReadReg2 = 5'd13;
    cycle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (a_o[k] !== 32'h0) begin bad++; $display("[TB] FAIL midreset_r6_discarded[%0d]: got %h want 0", k, a_o[k]); end
      total++;
      if (b_o[k] !== 32'h31) begin bad++; $display("[TB] FAIL midreset_r13[%0d]: got %h want 31", k, b_o[k]); end
      total++;
      if (cnt_o[k] !== 32'h0) begin bad++; $display("[TB] FAIL midreset_count_after[%0d]: got %0d want 0", k, cnt_o[k]); end
    end
  endtask

  task automatic test_zero_hardwired();
    ReadReg1 = 5'd0;
    wb_valid = 1; RegWrite = 1; MemtoReg = 0; WriteReg = 5'd0; ALUOut = 32'h1234;
    cycle();
    wb_valid = 0; RegWrite = 0;
    #1;
    total++;
    if (a_o[0] !== 32'h1234) begin bad++; $display("[TB] FAIL zero_plain_forward: got %h want 1234", a_o[0]); end
    total++;
    if (a_o[1] !== 32'h0) begin bad++; $display("[TB] FAIL zero_hw_forward: got %h want 0", a_o[1]); end
    cycle();
    total++;
    if (cnt_o[0] !== 32'd1) begin bad++; $display("[TB] FAIL zero_plain_count: got %0d want 1", cnt_o[0]); end
    total++;
    if (cnt_o[1] !== 32'd0) begin bad++; $display("[TB] FAIL zero_hw_count: got %0d want 0", cnt_o[1]); end
    total++;
    if (a_o[1] !== 32'h0) begin bad++; $display("[TB] FAIL zero_hw_array: got %h want 0", a_o[1]); end
    dbg_req = 1; dbg_addr = 5'd0; dbg_data = 32'h99;
    cycle();
    dbg_req = 0;
    cycle();
    total++;
    if (a_o[0] !== 32'h99) begin bad++; $display("[TB] FAIL zero_plain_dbg: got %h want 99", a_o[0]); end
    total++;
    if (a_o[1] !== 32'h0) begin bad++; $display("[TB] FAIL zero_hw_dbg: got %h want 0", a_o[1]); end
  endtask

  task automatic test_random();
    logic [31:0] ea;
    logic [31:0] eb;
    for (int i = 0; i < 400; i++) begin
      wb_valid = ($urandom_range(0, 3) != 0);
      RegWrite = ($urandom_range(0, 3) != 0);
      MemtoReg = $urandom_range(0, 1);
      WriteReg = 5'($urandom_range(0, 7));
      ALUOut   = $urandom;
      MemData  = $urandom;
      ReadReg1 = 5'($urandom_range(0, 9));
      ReadReg2 = 5'($urandom_range(0, 31));
      if (dbg_req && m_phase[0] == 2 && m_phase[1] == 2) begin
        dbg_req = 0;
      end else if (!dbg_req && m_phase[0] == 0 && m_phase[1] == 0 && $urandom_range(0, 5) == 0) begin
        dbg_req  = 1;
        dbg_addr = 5'($urandom_range(0, 9));
        dbg_data = $urandom;
      end
      cycle();
      for (int k = 0; k < 2; k++) begin
        ea = exp_read(k, ReadReg1);
        eb = exp_read(k, ReadReg2);
        total++;
        if (a_o[k] !== ea) begin bad++; $display("[TB] FAIL rand_A[%0d] cyc %0d r%0d: got %h want %h", k, i, ReadReg1, a_o[k], ea); end
        total++;
        if (b_o[k] !== eb) begin bad++; $display("[TB] FAIL rand_B[%0d] cyc %0d r%0d: got %h want %h", k, i, ReadReg2, b_o[k], eb); end
        total++;
        if (ack_o[k] !== (m_phase[k] == 1)) begin bad++; $display("[TB] FAIL rand_ack[%0d] cyc %0d: got %b want %b", k, i, ack_o[k], m_phase[k] == 1); end
        total++;
        if (cnt_o[k] !== m_count[k]) begin bad++; $display("[TB] FAIL rand_count[%0d] cyc %0d: got %0d want %0d", k, i, cnt_o[k], m_count[k]); end
      end
    end
  endtask

  initial begin
    RESET = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge CLK);
    test_reset();
    test_debug_write();
    test_capture();
    test_memtoreg();
    test_back_to_back();
    test_reset_mid();
    do_reset();
    test_zero_hardwired();
    idle_inputs();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
